// File: rtl/vgaconsole_pkg.sv
// vgaconsole_pkg: shared glyph geometry, renderer state type and ROM row-slice helper
// Exports:
//   GLYPH_W/GLYPH_H   glyph pixel size inside a cell (5x7)
//   CELL_W/CELL_H     cell size including the gap column/row (6x8)
//   ROM_W             character ROM word width (7 rows x 5 pixels)
//   state_t           renderer FSM states
//   glyph_row_slice() 5-pixel slice of one glyph row, blank for the gap row
package vgaconsole_pkg;
    localparam int GLYPH_W = 5;
    localparam int GLYPH_H = 7;
    localparam int CELL_W  = 6;
    localparam int CELL_H  = 8;
    localparam int ROM_W   = GLYPH_W * GLYPH_H;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_READY, S_RUN} state_t;

    // Row 0 sits in the top five bits; row 7 is the inter-line gap and is always blank.
    function automatic logic [GLYPH_W-1:0] glyph_row_slice(input logic [ROM_W-1:0] rom_data,
                                                           input logic [2:0] row);
        return (row == 3'd7) ? '0 : GLYPH_W'(rom_data >> (GLYPH_W * (GLYPH_H - 1 - int'(row))));
    endfunction
endpackage

// File: rtl/vgaconsole_pixel_shifter.sv
// vgaconsole_pixel_shifter: serialises one cell (glyph slice + gap column) into a scaled pixel stream
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_load         load {i_slice, 0} and emit its first pixel next cycle
//   i_en           advance through the current cell
//   i_slice        5-pixel glyph slice, MSB shown first
//   o_pixel        registered pixel; 0 whenever neither load nor advance happened
//   o_cell_end     high during the last clock of the current cell
module vgaconsole_pixel_shifter
    import vgaconsole_pkg::*;
#(
    parameter int PIX_SCALE = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_en,
    input  logic [GLYPH_W-1:0] i_slice,
    output logic               o_pixel,
    output logic               o_cell_end
);
    localparam int PW = (PIX_SCALE > 1) ? $clog2(PIX_SCALE) : 1;

    logic [CELL_W-1:0] r_sh;
    logic [PW-1:0]     r_pre;
    logic [2:0]        r_bit;
    logic              r_pixel;
    logic              w_step;

    // The pixel register is fed with the value the shifter will present next,
    // so the first glyph pixel appears on the cycle right after the load.
    assign w_step     = (r_pre == PW'(PIX_SCALE - 1));
    assign o_cell_end = w_step && (r_bit == 3'(CELL_W - 1));
    assign o_pixel    = r_pixel;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh    <= '0;
            r_pre   <= '0;
            r_bit   <= '0;
            r_pixel <= 1'b0;
        end else if (i_load) begin
            r_sh    <= {i_slice, 1'b0};
            r_pre   <= '0;
            r_bit   <= '0;
            r_pixel <= i_slice[GLYPH_W-1];
        end else if (i_en) begin
            r_pre   <= w_step ? '0 : r_pre + PW'(1);
            r_pixel <= w_step ? r_sh[CELL_W-2] : r_sh[CELL_W-1];
            if (w_step) begin
                r_sh  <= r_sh << 1;
                r_bit <= r_bit + 3'd1;
            end
        end else begin
            r_pixel <= 1'b0;
        end
    end
endmodule

// File: rtl/vgaconsole_glyph_renderer.sv
// vgaconsole_glyph_renderer: fetches character codes per scanline, looks up glyph rows and streams pixels
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_line_start      pulse: abort and prefetch column 0 of a new scanline
//   i_active          display enable for the text area of the current line
//   i_cell_row        row inside the character cell (0..7), stable for the line
//   o_char_req        one-cycle text-buffer read strobe
//   o_char_col        text-buffer column for o_char_req
//   i_char_code       text-buffer data, valid the cycle after o_char_req
//   o_rom_addr        registered character code driving the ROM
//   i_rom_data        combinational ROM glyph for o_rom_addr
//   o_pixel           foreground/background pixel
//   o_underrun        sticky: display enabled before a glyph was ready
module vgaconsole_glyph_renderer
    import vgaconsole_pkg::*;
#(
    parameter int NUM_COLS  = 20,
    parameter int PIX_SCALE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_line_start,
    input  logic             i_active,
    input  logic [2:0]       i_cell_row,
    output logic             o_char_req,
    output logic [5:0]       o_char_col,
    input  logic [6:0]       i_char_code,
    output logic [6:0]       o_rom_addr,
    input  logic [ROM_W-1:0] i_rom_data,
    output logic             o_pixel,
    output logic             o_underrun
);
    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    state_t             r_state, w_state_nx;
    logic [CW-1:0]      r_col;
    logic               r_char_req, r_f1, r_f2;
    logic               r_next_valid, r_underrun, r_line_done;
    logic [6:0]         r_rom_addr;
    logic [GLYPH_W-1:0] r_next_buf;
    logic               w_load, w_en, w_fetch, w_kill, w_end_line, w_more, w_cell_end;

    assign w_more     = (32'(r_col) + 1) < NUM_COLS;
    assign o_char_req = r_char_req;
    assign o_char_col = 6'(r_col);
    assign o_rom_addr = r_rom_addr;
    assign o_underrun = r_underrun;

    always_ff @(posedge i_clk) begin
        r_state <= i_rst ? S_IDLE : w_state_nx;
    end

    // A fetch takes three cycles against a six-cycle minimum cell, so a cell end
    // with no glyph pending can only mean every column has been shown.
    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_en       = 1'b0;
        w_fetch    = 1'b0;
        w_kill     = 1'b0;
        w_end_line = 1'b0;
        if (i_line_start) begin
            w_state_nx = S_FETCH;
            w_kill     = 1'b1;
        end else begin
            case (r_state)
                S_FETCH: w_state_nx = r_f2 ? S_READY : S_FETCH;
                S_READY: begin
                    if (i_active) begin
                        w_state_nx = S_RUN;
                        w_load     = 1'b1;
                        w_fetch    = w_more;
                    end
                end
                S_RUN: begin
                    if (!i_active) begin
                        w_state_nx = S_IDLE;
                        w_kill     = 1'b1;
                        w_end_line = 1'b1;
                    end else if (w_cell_end && r_next_valid) begin
                        w_load  = 1'b1;
                        w_fetch = w_more;
                    end else if (w_cell_end) begin
                        w_state_nx = S_IDLE;
                        w_end_line = 1'b1;
                    end else begin
                        w_en = 1'b1;
                    end
                end
                default: w_state_nx = r_state;
            endcase
        end
    end

    // Fetch pipeline: request -> code capture into rom_addr -> row slice into next_buf.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_col        <= '0;
            r_char_req   <= 1'b0;
            r_f1         <= 1'b0;
            r_f2         <= 1'b0;
            r_rom_addr   <= '0;
            r_next_buf   <= '0;
            r_next_valid <= 1'b0;
            r_line_done  <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_char_req   <= i_line_start || w_fetch;
            r_f1         <= r_char_req && !w_kill;
            r_f2         <= r_f1 && !w_kill;
            r_next_valid <= !w_kill && (r_f2 || (r_next_valid && !w_load));
            r_line_done  <= !i_line_start && (r_line_done || w_end_line);
            if (i_line_start) r_col <= '0;
            else if (w_fetch) r_col <= r_col + CW'(1);
            if (r_f1) r_rom_addr <= i_char_code;
            if (r_f2) r_next_buf <= glyph_row_slice(i_rom_data, i_cell_row);
            // Idle after a finished line is legitimate blanking, not a starved display.
            if (i_active && (r_state == S_FETCH || (r_state == S_IDLE && !r_line_done)))
                r_underrun <= 1'b1;
        end
    end

    vgaconsole_pixel_shifter #(.PIX_SCALE(PIX_SCALE)) u_shifter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_en       (w_en),
        .i_slice    (r_next_buf),
        .o_pixel    (o_pixel),
        .o_cell_end (w_cell_end)
    );
endmodule

// File: tb/tb_vgaconsole_glyph_renderer.sv
// tb_vgaconsole_glyph_renderer: scoreboard bench driving two renderer configurations with shared stimulus
module tb_vgaconsole_glyph_renderer;
  typedef struct {
    int cyc;
    int dut;
    int kind;
    int val;
  } exp_t;
  logic        clk, rst, line_start, active;
  logic [2:0]  cell_row;
  logic        req[2], pix[2], und[2];
  logic [5:0]  col[2];
  logic [6:0]  code[2], ra[2];
  logic [34:0] rd[2];
  logic [6:0]  text[64];
  logic [4:0]  ga[7] = '{5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001};
  logic [4:0]  gb[7] = '{5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10001, 5'b10001, 5'b11110};
  string       names[5] = '{"pixel", "char_req", "char_col", "underrun", "rom_addr"};
  exp_t        q[$];
  int          cyc = 0, base = 0, checks = 0, fails = 0;

  function automatic logic [4:0] gl(input int c, input int row);
    if (row == 7) return 5'b0;
    if (c < 32) return 5'h1f;
    if (c == 65) return ga[row];
    if (c == 66) return gb[row];
    return 5'b0;
  endfunction

  function automatic logic [34:0] rom35(input logic [6:0] c);
    logic [34:0] r = '0;
    for (int i = 0; i < 7; i++) r = {r[29:0], gl(int'(c), i)};
    return r;
  endfunction

  function automatic int px(input int c, input int row, input int pos);
    logic [4:0] s;
    s = gl(c, row);
    return (pos < 5) ? int'(s[4 - pos]) : 0;
  endfunction

  function automatic int get(input int d, input int k);
    case (k)
      0: return int'(pix[d]);
      1: return int'(req[d]);
      2: return int'(col[d]);
      3: return int'(und[d]);
      4: return int'(ra[d]);
      default: return -1;
    endcase
  endfunction

  vgaconsole_glyph_renderer #(.NUM_COLS(3), .PIX_SCALE(1)) u0 (
    .i_clk(clk), .i_rst(rst), .i_line_start(line_start), .i_active(active),
    .i_cell_row(cell_row), .o_char_req(req[0]), .o_char_col(col[0]),
    .i_char_code(code[0]), .o_rom_addr(ra[0]), .i_rom_data(rd[0]),
    .o_pixel(pix[0]), .o_underrun(und[0])
  );

  vgaconsole_glyph_renderer #(.NUM_COLS(2), .PIX_SCALE(2)) u1 (
    .i_clk(clk), .i_rst(rst), .i_line_start(line_start), .i_active(active),
    .i_cell_row(cell_row), .o_char_req(req[1]), .o_char_col(col[1]),
    .i_char_code(code[1]), .o_rom_addr(ra[1]), .i_rom_data(rd[1]),
    .o_pixel(pix[1]), .o_underrun(und[1])
  );

  assign rd[0] = rom35(ra[0]);
  assign rd[1] = rom35(ra[1]);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (req[0]) code[0] <= text[col[0]];
    if (req[1]) code[1] <= text[col[1]];
  end

  always @(negedge clk) begin : monitor
    int a;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        a = get(q[i].dut, q[i].kind);
        checks++;
        if (a != q[i].val) begin
          fails++;
          $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d",
                   names[q[i].kind], q[i].dut, cyc, a, q[i].val);
        end
        q.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input int d, input int k, input int rel, input int v);
    exp_t e;
    e.cyc  = base + rel;
    e.dut  = d;
    e.kind = k;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic exp_line(input int d, input int nc, input int ps, input int row,
                          input int lo, input int hi, input int start);
    for (int rel = lo; rel <= hi; rel++) begin
      int n, v;
      n = rel - start;
      v = 0;
      if (n >= 0 && n / (6 * ps) < nc) v = px(int'(text[n / (6 * ps)]), row, (n % (6 * ps)) / ps);
      ex(d, 0, rel, v);
    end
  endtask

  task automatic exp_req(input int d, input int lo, input int hi, input int at[6], input int cl[6]);
    for (int rel = lo; rel <= hi; rel++) begin
      int hit;
      hit = -1;
      for (int j = 0; j < 6; j++) if (at[j] == rel) hit = j;
      ex(d, 1, rel, (hit >= 0) ? 1 : 0);
      if (hit >= 0) ex(d, 2, rel, cl[hit]);
    end
  endtask

  task automatic exp_zero(input int rel);
    for (int d = 0; d < 2; d++) for (int k = 0; k < 5; k++) ex(d, k, rel, 0);
  endtask

  task automatic drive(input int len, input int ls2, input int a_on, input int a_off,
                       input int rst_at, input int row);
    cell_row = 3'(row);
    for (int r = 0; r < len; r++) begin
      line_start = (r == 0 || r == ls2);
      active     = (r >= a_on && r < a_off);
      rst        = (r == rst_at);
      tick();
    end
    line_start = 1'b0;
    active     = 1'b0;
    rst        = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) text[i] = 7'h20;
    text[0] = 7'h41;
    text[1] = 7'h42;
    text[2] = 7'h05;
    code[0] = '0;
    code[1] = '0;
    rst = 1'b1;
    line_start = 1'b0;
    active = 1'b0;
    cell_row = 3'd0;
    tick();
    tick();
    base = cyc;
    exp_zero(0);
    rst = 1'b0;
    tick();
    base = cyc;
    exp_line(0, 3, 1, 0, 1, 35, 5);
    exp_line(1, 2, 2, 0, 1, 35, 5);
    exp_req(0, 1, 35, '{1, 5, 11, -1, -1, -1}, '{0, 1, 2, 0, 0, 0});
    exp_req(1, 1, 35, '{1, 5, -1, -1, -1, -1}, '{0, 1, 0, 0, 0, 0});
    ex(0, 4, 3, 65);
    ex(0, 4, 13, 5);
    ex(1, 4, 7, 66);
    ex(0, 3, 34, 0);
    ex(1, 3, 34, 0);
    drive(36, -1, 4, 33, -1, 0);
    base = cyc;
    exp_line(0, 3, 1, 7, 1, 27, 5);
    exp_line(1, 2, 2, 7, 1, 27, 5);
    exp_req(0, 1, 27, '{1, 5, 11, -1, -1, -1}, '{0, 1, 2, 0, 0, 0});
    drive(28, -1, 4, 26, -1, 7);
    base = cyc;
    ex(0, 3, 2, 0);
    for (int rel = 3; rel <= 26; rel++) begin
      ex(0, 3, rel, 1);
      ex(1, 3, rel, 1);
    end
    exp_line(0, 3, 1, 1, 1, 13, 5);
    exp_line(0, 3, 1, 1, 14, 26, 18);
    exp_line(1, 2, 2, 1, 1, 13, 5);
    exp_line(1, 2, 2, 1, 14, 26, 18);
    exp_req(0, 1, 26, '{1, 5, 11, 14, 18, 24}, '{0, 1, 2, 0, 1, 2});
    exp_req(1, 1, 26, '{1, 5, 14, 18, -1, -1}, '{0, 1, 0, 1, 0, 0});
    exp_zero(27);
    ex(0, 3, 28, 0);
    ex(1, 3, 28, 0);
    drive(30, 13, 2, 27, 26, 1);
    base = cyc;
    exp_line(0, 3, 1, 0, 1, 19, 5);
    exp_line(0, 3, 1, 0, 20, 24, 1000);
    exp_line(1, 2, 2, 0, 1, 19, 5);
    exp_line(1, 2, 2, 0, 20, 24, 1000);
    exp_req(0, 1, 24, '{1, 5, 11, -1, -1, -1}, '{0, 1, 2, 0, 0, 0});
    exp_req(1, 1, 24, '{1, 5, -1, -1, -1, -1}, '{0, 1, 0, 0, 0, 0});
    ex(0, 3, 25, 0);
    ex(1, 3, 25, 0);
    drive(26, -1, 4, 19, -1, 0);
    tick();
    tick();
    foreach (q[i]) begin
      checks++;
      fails++;
      $display("FAIL %s dut%0d cycle %0d: never sampled, expected %0d",
               names[q[i].kind], q[i].dut, q[i].cyc, q[i].val);
    end
    if (checks == 0) begin
      fails++;
      $display("FAIL no expectations were sampled");
    end
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %0d expectations left unsampled", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
